// File: rtl/spi_dac_master_mc.sv
// Multi-channel SPI master for AD5791-class DACs with LDAC / CLR pulse generation.
// Define SPI_DAC_READBACK_EN to sample SDO and return it on the m_axis port.
module spi_dac_master_mc #(
    parameter int DATA_W   = 24,
    parameter int CLK_DIV  = 1,
    parameter int CPOL     = 1,
    parameter int N_CS     = 2,
    parameter int LDAC_W   = 2,
    parameter int SYNC_GAP = 2,
    localparam int CSW     = (N_CS > 1) ? $clog2(N_CS) : 1
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic [CSW-1:0]    s_axis_tuser,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              clr_req,
    input  logic              miso,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [CSW-1:0]    m_axis_tuser,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              sclk,
    output logic              sdin,
    output logic [N_CS-1:0]   sync_n,
    output logic              ldac_n,
    output logic              clr_n,
    output logic              busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DROP  = 3'd1;
    localparam logic [2:0] S_LEAD  = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_TRAIL = 3'd4;
    localparam logic [2:0] S_LDAC  = 3'd5;
    localparam logic [2:0] S_GAP   = 3'd6;
    localparam logic [2:0] S_CLR   = 3'd7;
    localparam int   BW       = $clog2(DATA_W) + 1;
    localparam logic IDLE_LVL = 1'(CPOL);

    logic [2:0]        state;
    logic [15:0]       cnt;
    logic [BW-1:0]     bit_cnt;
    logic              armed;
    logic [DATA_W-1:0] tx;
    logic [CSW-1:0]    ch;
    logic              last;
    logic              hs, tick, ch_ok, samp_edge, adv, trail_done, rb_block, bits_done;

    assign hs         = s_axis_tvalid && s_axis_tready;
    assign tick       = (cnt == 16'(CLK_DIV));
    assign ch_ok      = (32'(s_axis_tuser) < N_CS);
    assign bits_done  = (bit_cnt == BW'(DATA_W));
    // The first edge out of LEAD is already a sampling edge.
    assign samp_edge  = (state == S_LEAD && tick) ||
                        (state == S_SHIFT && tick && sclk == IDLE_LVL && !bits_done);
    assign adv        = state == S_SHIFT && tick && sclk != IDLE_LVL && !bits_done;
    assign trail_done = (state == S_TRAIL) && tick;

    assign s_axis_tready = armed && (state == S_IDLE) && !clr_req && !rb_block;
    assign busy          = (state != S_IDLE);
    assign m_axis_tuser  = ch;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            armed   <= 1'b0;
            sclk    <= IDLE_LVL;
            sdin    <= 1'b0;
            sync_n  <= '1;
            ldac_n  <= 1'b1;
            clr_n   <= 1'b1;
        end else begin
            armed <= 1'b1;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (armed && clr_req) begin
                        state <= S_CLR;
                        clr_n <= 1'b0;
                    end else if (hs) begin
                        if (ch_ok) begin
                            state  <= S_LEAD;
                            sync_n <= ~(N_CS'(1) << s_axis_tuser);
                            sdin   <= s_axis_tdata[DATA_W-1];
                        end else begin
                            state <= S_DROP;
                        end
                    end
                end
                S_DROP: state <= S_IDLE;
                S_LEAD: begin
                    if (tick) begin
                        cnt     <= '0;
                        sclk    <= ~IDLE_LVL;
                        bit_cnt <= BW'(1);
                        state   <= S_SHIFT;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_SHIFT: begin
                    if (tick) begin
                        cnt <= '0;
                        if (sclk != IDLE_LVL) begin
                            sclk <= IDLE_LVL;
                            if (adv) sdin <= tx[DATA_W-2];
                        end else if (bits_done) begin
                            state <= S_TRAIL;
                        end else begin
                            sclk    <= ~IDLE_LVL;
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_TRAIL: begin
                    if (trail_done) begin
                        cnt    <= '0;
                        sync_n <= '1;
                        sdin   <= 1'b0;
                        ldac_n <= ~last;
                        state  <= last ? S_LDAC : S_GAP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_LDAC: begin
                    if (cnt == 16'(LDAC_W - 1)) begin
                        cnt    <= '0;
                        ldac_n <= 1'b1;
                        state  <= S_GAP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_CLR: begin
                    if (cnt == 16'(LDAC_W - 1)) begin
                        cnt   <= '0;
                        clr_n <= 1'b1;
                        state <= S_GAP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_GAP: begin
                    if (cnt == 16'(SYNC_GAP - 1)) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (hs) begin
            tx   <= s_axis_tdata;
            ch   <= s_axis_tuser;
            last <= s_axis_tlast;
        end else if (adv) begin
            tx <= {tx[DATA_W-2:0], 1'b0};
        end
    end

`ifdef SPI_DAC_READBACK_EN
    logic [DATA_W-1:0] rx;

    always_ff @(posedge aclk) begin
        if (samp_edge) rx <= {rx[DATA_W-2:0], miso};
    end

    // Readback word is presented as sync_n rises and held until accepted.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
        end else if (trail_done) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= rx;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    assign rb_block = m_axis_tvalid;
`else
    logic unused_rb;
    assign unused_rb     = &{1'b0, miso, m_axis_tready, samp_edge};
    assign m_axis_tvalid = 1'b0;
    assign m_axis_tdata  = '0;
    assign rb_block      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_dac_master_mc.sv
// Directed bench for spi_dac_master_mc: frame timing, LDAC/CLR pulses, drop, readback, reset.
module tb_spi_dac_master_mc;
    logic aclk = 1'b0;
    logic aresetn = 1'b1;
    always #5 aclk = ~aclk;

    logic [23:0] s_tdata = '0;
    logic        s_tuser = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        clr_req = 1'b0;
    logic        miso = 1'b0;
    logic [23:0] m_tdata;
    logic        m_tuser;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        sclk, sdin, ldac_n, clr_n, busy;
    logic [1:0]  sync_n;

    spi_dac_master_mc dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .clr_req(clr_req), .miso(miso),
        .m_axis_tdata(m_tdata), .m_axis_tuser(m_tuser), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .sclk(sclk), .sdin(sdin), .sync_n(sync_n),
        .ldac_n(ldac_n), .clr_n(clr_n), .busy(busy)
    );

    // Three-channel instance so that an out-of-range tuser (3) is expressible.
    logic [23:0] b_tdata = '0;
    logic [1:0]  b_tuser = '0;
    logic        b_tvalid = 1'b0;
    logic        b_tready, b_mtvalid, b_sclk, b_sdin, b_ldac_n, b_clr_n, b_busy;
    logic [23:0] b_mtdata;
    logic [1:0]  b_mtuser;
    logic [2:0]  b_sync_n;

    spi_dac_master_mc #(.N_CS(3)) dut3 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(b_tdata), .s_axis_tuser(b_tuser), .s_axis_tlast(1'b0),
        .s_axis_tvalid(b_tvalid), .s_axis_tready(b_tready), .clr_req(1'b0), .miso(1'b0),
        .m_axis_tdata(b_mtdata), .m_axis_tuser(b_mtuser), .m_axis_tvalid(b_mtvalid),
        .m_axis_tready(1'b1), .sclk(b_sclk), .sdin(b_sdin), .sync_n(b_sync_n),
        .ldac_n(b_ldac_n), .clr_n(b_clr_n), .busy(b_busy)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    // Pin monitor and SDO model, evaluated mid-cycle.
    logic        mon_en = 1'b0;
    logic [23:0] miso_pat = '0;
    logic [23:0] rx_word = '0;
    logic [1:0]  sync_low_val = 2'b11;
    logic        prev_sclk = 1'b1, prev_ldac = 1'b1, prev_clr = 1'b1, prev_tready = 1'b0;
    logic        first_pend = 1'b0;
    logic [1:0]  prev_sync = 2'b11;
    int fall_cnt = 0, first_fall_cyc = 0, last_edge_cyc = 0, miso_idx = 0;
    int sync_fall_cyc = 0, sync_rise_cyc = 0, last_gap = 0;
    int ldac_low = 0, ldac_fall_cyc = 0, clr_low = 0, clr_fall_cyc = 0;
    int tready_rise_cyc = 0, multi_err = 0, b_act = 0;

    always @(negedge aclk) begin
        if (mon_en) begin
            if (prev_sclk && !sclk) begin
                rx_word = {rx_word[22:0], sdin};
                fall_cnt++;
                last_edge_cyc = cyc;
                if (first_pend) begin
                    first_fall_cyc = cyc;
                    first_pend = 1'b0;
                end
            end
            if (!prev_sclk && sclk) begin
                last_edge_cyc = cyc;
                if (miso_idx > 0) begin
                    miso_idx--;
                    miso = miso_pat[miso_idx];
                end
            end
            if (prev_sync == 2'b11 && sync_n != 2'b11) begin
                sync_fall_cyc = cyc;
                sync_low_val = sync_n;
                last_gap = cyc - sync_rise_cyc;
                first_pend = 1'b1;
                miso_idx = 23;
                miso = miso_pat[23];
            end
            if (prev_sync != 2'b11 && sync_n == 2'b11) sync_rise_cyc = cyc;
            if (!ldac_n) begin
                ldac_low++;
                if (prev_ldac) ldac_fall_cyc = cyc;
            end
            if (!clr_n) begin
                clr_low++;
                if (prev_clr) clr_fall_cyc = cyc;
            end
            if (s_tready && !prev_tready) tready_rise_cyc = cyc;
            if (sync_n == 2'b00) multi_err++;
            if (b_sync_n != 3'b111 || !b_sclk) b_act++;
        end
        prev_sclk = sclk;
        prev_sync = sync_n;
        prev_ldac = ldac_n;
        prev_clr = clr_n;
        prev_tready = s_tready;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge aclk);
            #2;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step(1);
    endtask

    task automatic send(input logic [23:0] d, input logic u, input logic l, output int t0);
        int n = 0;
        s_tdata = d; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
        while (!s_tready && n < 300) begin
            step(1);
            n++;
        end
        checks++;
        if (s_tready !== 1'b1) begin
            failures++;
            $display("FAIL send_timeout: tready=%b after %0d cycles, want 1", s_tready, n);
        end
        t0 = cyc;
        step(1);
        s_tvalid = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        step(3);
        checks++;
        if ({sclk, sdin, sync_n, ldac_n, clr_n, s_tready, m_tvalid, busy} !== 9'b1_0_11_1_1_0_0_0) begin
            failures++;
            $display("FAIL reset_pins: got %b want 101111000",
                     {sclk, sdin, sync_n, ldac_n, clr_n, s_tready, m_tvalid, busy});
        end
        checks++;
        if (m_tdata !== 24'h0) begin
            failures++;
            $display("FAIL reset_mtdata: got %h want 000000", m_tdata);
        end
        aresetn = 1'b1;
        step(2);
        mon_en = 1'b1;
        checks++;
        if (s_tready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_ready: tready=%b busy=%b want 1 0", s_tready, busy);
        end
    endtask

    task automatic test_single();
        int t0, f0, l0;
        miso_pat = 24'hA5A5A5;
        f0 = fall_cnt; l0 = ldac_low;
        send(24'h123456, 1'b1, 1'b1, t0);
        wait_until(t0 + 110);
        checks++;
        if (sync_fall_cyc !== t0 + 1) begin failures++; $display("FAIL sync_fall: got T0+%0d want T0+1", sync_fall_cyc - t0); end
        checks++;
        if (sync_low_val !== 2'b01) begin failures++; $display("FAIL sync_val: got %b want 01", sync_low_val); end
        checks++;
        if (first_fall_cyc !== t0 + 3) begin failures++; $display("FAIL first_edge: got T0+%0d want T0+3", first_fall_cyc - t0); end
        checks++;
        if (last_edge_cyc !== t0 + 97) begin failures++; $display("FAIL last_edge: got T0+%0d want T0+97", last_edge_cyc - t0); end
        checks++;
        if (fall_cnt - f0 !== 24) begin failures++; $display("FAIL fall_count: got %0d want 24", fall_cnt - f0); end
        checks++;
        if (rx_word !== 24'h123456) begin failures++; $display("FAIL sdin_word: got %h want 123456", rx_word); end
        checks++;
        if (sync_rise_cyc !== t0 + 101) begin failures++; $display("FAIL sync_rise: got T0+%0d want T0+101", sync_rise_cyc - t0); end
        checks++;
        if (ldac_fall_cyc !== t0 + 101) begin failures++; $display("FAIL ldac_start: got T0+%0d want T0+101", ldac_fall_cyc - t0); end
        checks++;
        if (ldac_low - l0 !== 2) begin failures++; $display("FAIL ldac_width: got %0d want 2", ldac_low - l0); end
        checks++;
        if (tready_rise_cyc !== t0 + 105) begin failures++; $display("FAIL tready_back: got T0+%0d want T0+105", tready_rise_cyc - t0); end
    endtask

    task automatic test_back_to_back();
        int ta, tb, l0;
        l0 = ldac_low;
        send(24'hABCDEF, 1'b0, 1'b0, ta);
        send(24'h0F0F0F, 1'b1, 1'b1, tb);
        checks++;
        if (tb !== ta + 103) begin failures++; $display("FAIL b2b_accept: got T0+%0d want T0+103", tb - ta); end
        checks++;
        if (rx_word !== 24'hABCDEF || sync_low_val !== 2'b10) begin
            failures++;
            $display("FAIL b2b_first: word %h sync %b want abcdef 10", rx_word, sync_low_val);
        end
        checks++;
        if (ldac_low - l0 !== 0) begin failures++; $display("FAIL b2b_no_ldac: got %0d low cycles want 0", ldac_low - l0); end
        wait_until(tb + 110);
        checks++;
        if (last_gap !== 3) begin failures++; $display("FAIL b2b_gap: got %0d want 3", last_gap); end
        checks++;
        if (rx_word !== 24'h0F0F0F || sync_low_val !== 2'b01) begin
            failures++;
            $display("FAIL b2b_second: word %h sync %b want 0f0f0f 01", rx_word, sync_low_val);
        end
        checks++;
        if (ldac_low - l0 !== 2) begin failures++; $display("FAIL b2b_ldac: got %0d want 2", ldac_low - l0); end
    endtask

    task automatic test_drop();
        int n = 0, a0;
        a0 = b_act;
        b_tdata = 24'hFFFFFF; b_tuser = 2'd3; b_tvalid = 1'b1;
        while (!b_tready && n < 50) begin step(1); n++; end
        step(1);
        b_tvalid = 1'b0;
        checks++;
        if (b_busy !== 1'b1 || b_tready !== 1'b0) begin
            failures++;
            $display("FAIL drop_t1: busy=%b tready=%b want 1 0", b_busy, b_tready);
        end
        step(1);
        checks++;
        if (b_tready !== 1'b1) begin failures++; $display("FAIL drop_ready: got %b want 1", b_tready); end
        step(4);
        checks++;
        if (b_act !== a0 || b_sync_n !== 3'b111) begin
            failures++;
            $display("FAIL drop_pins: activity %0d sync %b want 0 111", b_act - a0, b_sync_n);
        end
    endtask

    task automatic test_clr();
        int t0, tc, c0, l0;
        c0 = clr_low; l0 = ldac_low;
        send(24'h555555, 1'b0, 1'b0, t0);
        wait_until(t0 + 20);
        clr_req = 1'b1;
        while (clr_n !== 1'b0 && cyc < t0 + 200) step(1);
        tc = cyc;
        clr_req = 1'b0;
        wait_until(t0 + 115);
        checks++;
        if (tc !== t0 + 104 || clr_fall_cyc !== t0 + 104) begin
            failures++;
            $display("FAIL clr_start: got T0+%0d want T0+104", tc - t0);
        end
        checks++;
        if (clr_low - c0 !== 2) begin failures++; $display("FAIL clr_width: got %0d want 2", clr_low - c0); end
        checks++;
        if (rx_word !== 24'h555555 || sync_rise_cyc !== t0 + 101) begin
            failures++;
            $display("FAIL clr_frame: word %h rise T0+%0d want 555555 T0+101", rx_word, sync_rise_cyc - t0);
        end
        checks++;
        if (sync_fall_cyc !== t0 + 1 || ldac_low !== l0 || s_tready !== 1'b1) begin
            failures++;
            $display("FAIL clr_quiet: fall T0+%0d ldac %0d tready %b want T0+1 0 1",
                     sync_fall_cyc - t0, ldac_low - l0, s_tready);
        end
    endtask

    task automatic test_readback();
        int t0;
        miso_pat = 24'hA5A5A5;
        m_tready = 1'b0;
        send(24'h000001, 1'b0, 1'b0, t0);
        wait_until(t0 + 110);
`ifdef SPI_DAC_READBACK_EN
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 24'hA5A5A5 || m_tuser !== 1'b0) begin
            failures++;
            $display("FAIL rb_word: valid %b data %h user %b want 1 a5a5a5 0", m_tvalid, m_tdata, m_tuser);
        end
        step(10);
        checks++;
        if (s_tready !== 1'b0 || m_tdata !== 24'hA5A5A5) begin
            failures++;
            $display("FAIL rb_hold: tready %b data %h want 0 a5a5a5", s_tready, m_tdata);
        end
        m_tready = 1'b1;
        step(1);
        m_tready = 1'b0;
        checks++;
        if (m_tvalid !== 1'b0 || s_tready !== 1'b1) begin
            failures++;
            $display("FAIL rb_release: valid %b tready %b want 0 1", m_tvalid, s_tready);
        end
`else
        checks++;
        if (m_tvalid !== 1'b0 || m_tdata !== 24'h0 || s_tready !== 1'b1) begin
            failures++;
            $display("FAIL rb_off: valid %b data %h tready %b want 0 000000 1", m_tvalid, m_tdata, s_tready);
        end
`endif
        m_tready = 1'b1;
        step(1);
    endtask

    task automatic test_reset_mid();
        int t0, t1, f0;
        send(24'h777777, 1'b1, 1'b0, t0);
        wait_until(t0 + 30);
        aresetn = 1'b0;
        #1;
        checks++;
        if ({sclk, sdin, sync_n, ldac_n, clr_n, s_tready, m_tvalid, busy} !== 9'b1_0_11_1_1_0_0_0) begin
            failures++;
            $display("FAIL midreset_pins: got %b want 101111000",
                     {sclk, sdin, sync_n, ldac_n, clr_n, s_tready, m_tvalid, busy});
        end
        step(2);
        aresetn = 1'b1;
        step(2);
        f0 = fall_cnt;
        send(24'h3C3C3C, 1'b0, 1'b0, t1);
        wait_until(t1 + 110);
        checks++;
        if (rx_word !== 24'h3C3C3C || fall_cnt - f0 !== 24) begin
            failures++;
            $display("FAIL midreset_frame: word %h edges %0d want 3c3c3c 24", rx_word, fall_cnt - f0);
        end
        checks++;
        if (sync_fall_cyc !== t1 + 1 || sync_rise_cyc !== t1 + 101 || sync_low_val !== 2'b10) begin
            failures++;
            $display("FAIL midreset_sync: fall T0+%0d rise T0+%0d val %b want T0+1 T0+101 10",
                     sync_fall_cyc - t1, sync_rise_cyc - t1, sync_low_val);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_drop();
        test_clr();
        test_readback();
        test_reset_mid();
        checks++;
        if (multi_err !== 0) begin failures++; $display("FAIL one_hot_sync: %0d cycles with two sync_n low", multi_err); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
